// File: rtl/cycle_sequencer_if.sv
// Handshake bundle between the conversion FSM / readout logic and cycle_sequencer.
// The master side drives sequence control and increments; the slave is the sequencer.
interface cycle_sequencer_if #(
    parameter int WIDTH       = 5,
    parameter int FRAME_WIDTH = 8
);
    logic                   start_i;
    logic [WIDTH-1:0]       terminal_i;
    logic                   continuous_i;
    logic                   increment_i;
    logic                   abort_i;
    logic                   busy_o;
    logic                   stop_o;
    logic                   done_o;
    logic [WIDTH-1:0]       cycle_count_o;
    logic [FRAME_WIDTH-1:0] frames_o;

    modport master (
        output start_i, terminal_i, continuous_i, increment_i, abort_i,
        input  busy_o, stop_o, done_o, cycle_count_o, frames_o
    );

    modport slave (
        input  start_i, terminal_i, continuous_i, increment_i, abort_i,
        output busy_o, stop_o, done_o, cycle_count_o, frames_o
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Conversion-cycle sequencer: counts increments up to a run-time terminal,
// one-shot or auto-wrapping, and counts completed sequences (saturating).
//
// state | meaning
// IDLE  | waiting for start; count held at 0, increments ignored
// RUN   | counting; terminal cycle is RUN with count == term_q (stop_o high)
module cycle_sequencer #(
    parameter int WIDTH            = 5,
    parameter int DEFAULT_TERMINAL = 24,
    parameter int FRAME_WIDTH      = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    cycle_sequencer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]       DEF_TERM  = WIDTH'(DEFAULT_TERMINAL);
    localparam logic [FRAME_WIDTH-1:0] FRAME_MAX = '1;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       term_q, term_d;
    logic [FRAME_WIDTH-1:0] frames_q, frames_d;
    logic                   done_q, done_d;
    logic                   terminal_hit;

    // Terminal cycle is a RUN condition decoded straight from registered state.
    assign terminal_hit = (state_q == RUN) && (count_q == term_q);

    // Next-state logic: abort beats terminal handling, which beats increment.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        term_d   = term_q;
        frames_d = frames_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (bus.start_i && !bus.abort_i) begin
                    term_d   = (bus.terminal_i == '0) ? DEF_TERM : bus.terminal_i;
                    frames_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (terminal_hit) begin
                    // The increment arriving in the terminal cycle is dropped.
                    count_d = '0;
                    if (frames_q != FRAME_MAX) begin
                        frames_d = frames_q + FRAME_WIDTH'(1);
                    end
                    if (!bus.continuous_i) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (bus.increment_i) begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            term_q   <= DEF_TERM;
            frames_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            term_q   <= term_d;
            frames_q <= frames_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy_o        = (state_q == RUN);
    assign bus.stop_o        = terminal_hit;
    assign bus.done_o        = done_q;
    assign bus.cycle_count_o = count_q;
    assign bus.frames_o      = frames_q;

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Parametrised successor to the voltmeter's fixed 25-cycle counter. It counts conversion cycles up to a terminal count that is loaded at run time when a sequence starts. It supports one-shot or continuous (auto-wrap) operation and reports sequence completion through a start/busy/done handshake. It sits between the conversion FSM, which drives `increment_i` once per completed integrate/de-integrate cycle, and the readout logic, which consumes `done_o` and `frames_o`.

## Interface
- `WIDTH`, 5: width of the cycle counter and of the terminal count.
- `DEFAULT_TERMINAL`, 24: terminal used when `terminal_i` is 0 at start. Must satisfy 1 ≤ value ≤ 2^WIDTH−1.
- `FRAME_WIDTH`, 8: width of the completed-sequence counter.

Ports:
- `clk_i` input 1: single clock. All logic is rising-edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: begin a sequence. Honoured only in IDLE.
- `terminal_i` input WIDTH: terminal count, sampled on an accepted start.
- `continuous_i` input 1: sampled live in the terminal cycle. 1 = wrap and keep running; 0 = finish.
- `increment_i` input 1: advance the count by one. Honoured only in RUN.
- `abort_i` input 1: cancel the sequence and return to IDLE.
- `busy_o` output 1: high while in RUN.
- `stop_o` output 1: high in the terminal cycle (RUN and count == latched terminal).
- `done_o` output 1: one-cycle pulse after a one-shot sequence completes.
- `cycle_count_o` output WIDTH: current count.
- `frames_o` output FRAME_WIDTH: number of completed sequences since the last accepted start. Saturating.

## Operation
- States: IDLE, RUN. The terminal cycle is a RUN condition, not a separate state.
- Reset (`rst_i`=1 at an edge) forces the following, overriding all inputs, including mid-sequence:
  - state IDLE
  - count 0, `frames_o` 0
  - `done_o` 0
  - latched terminal `term_q` = DEFAULT_TERMINAL
- Priority: reset > abort > terminal handling > increment/start.
- IDLE:
  - Count is held at 0, `busy_o` is 0, and `increment_i` is ignored.
  - On `start_i`=1 the block:
    - latches `term_q` = (`terminal_i`==0 ? DEFAULT_TERMINAL : `terminal_i`);
    - clears `frames_o`;
    - moves to RUN.
- RUN, non-terminal cycle (count != `term_q`):
  - `increment_i`=1 sets count ← count+1; otherwise count holds.
  - `start_i` is ignored.
- RUN, terminal cycle (count == `term_q`):
  - `stop_o`=1.
  - Next edge: count ← 0 regardless of `increment_i` (that increment is dropped), and `frames_o` ← `frames_o`+1, saturating at 2^FRAME_WIDTH−1.
  - If `continuous_i`=1, stay in RUN.
  - If `continuous_i`=0, go to IDLE and assert `done_o` for the following cycle.
- `abort_i`=1 in RUN:
  - Next edge: state IDLE, count 0.
  - No `done_o`; `frames_o` is not incremented.
  - Abort takes precedence even in the terminal cycle.
  - `abort_i` in IDLE has no effect and suppresses a simultaneous `start_i`.
- Arithmetic: count never exceeds `term_q` ≤ 2^WIDTH−1, so no wrap of the WIDTH-bit adder is reachable. `frames_o` never wraps.

## Timing
- Start accepted at edge t: `busy_o`=1 and count=0 from t.
- Increment sampled at edge k: `cycle_count_o` updates immediately after edge k.
- Minimum one-shot sequence: `term_q` increments + 1 terminal cycle. With T=24 and `increment_i` held high, `stop_o` is high in cycle 25 after start, and `done_o` pulses in cycle 26.
- `stop_o` is combinational from registered state and count. It is high for exactly one cycle per terminal.
- `done_o` is registered: high in the cycle after the terminal cycle, concurrent with `busy_o`=0.
- `start_i` is accepted in the same cycle `done_o` is high (state is IDLE), giving back-to-back sequences with a one-cycle gap.
- Output reset values: `busy_o` 0, `stop_o` 0, `done_o` 0, `cycle_count_o` 0, `frames_o` 0.

## Test plan
- Reset then start with `terminal_i`=0 and `increment_i` held high → count runs 0..24; `stop_o` is high only at count 24; `done_o` pulses once; `busy_o` falls; `frames_o`=1.
- Start with `terminal_i`=3, `increment_i` toggling every other cycle → count changes only on high cycles; `stop_o` at count 3; `done_o` follows one cycle later; count 0.
- Continuous with `terminal_i`=2 and `increment_i` held high → `stop_o` every 3 cycles and no `done_o`. Drop `continuous_i` before the 4th terminal → `done_o` after that terminal; `frames_o`=4.
- Abort at count 10 (T=24) → IDLE and count 0 next cycle; no `done_o`; `frames_o` unchanged. Abort in the terminal cycle → no `done_o`.
- `start_i` and `increment_i` asserted during RUN and in the terminal cycle → start ignored; count resets to 0 (not 1) after the terminal; `term_q` unchanged.
- Assert `rst_i` mid-sequence at count 7 → all outputs 0 next cycle. `FRAME_WIDTH`=2 in continuous mode run for 5 frames → `frames_o` saturates at 3.
